// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared widths, limits and state encoding for the Genius score path
package genius_pkg;

  localparam int ROUND_W   = 4;
  localparam int LEVEL_W   = 2;
  localparam int POINTS_W  = 8;
  localparam int MAX_ROUND = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORE  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/genius_points_calc.sv
// rtl/genius_points_calc.sv - combinational level * round product, zero-extended to points width
module genius_points_calc #(
  parameter int ROUND_W  = genius_pkg::ROUND_W,
  parameter int LEVEL_W  = genius_pkg::LEVEL_W,
  parameter int POINTS_W = genius_pkg::POINTS_W
) (
  input  logic [LEVEL_W-1:0]  level,
  input  logic [ROUND_W-1:0]  round,
  output logic [POINTS_W-1:0] product
);

  // Both operands are widened first so the multiply is evaluated at points width.
  assign product = POINTS_W'(level) * POINTS_W'(round);

endmodule

// File: rtl/genius_score_ctrl.sv
// rtl/genius_score_ctrl.sv - Genius round sequencer, final points and per-level best score
module genius_score_ctrl #(
  parameter int ROUND_W   = genius_pkg::ROUND_W,
  parameter int LEVEL_W   = genius_pkg::LEVEL_W,
  parameter int POINTS_W  = genius_pkg::POINTS_W,
  parameter int MAX_ROUND = genius_pkg::MAX_ROUND
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                hit,
  input  logic                miss,
  input  logic [LEVEL_W-1:0]  setup_level,
  input  logic [1:0]          setup_mapa,
  output logic [LEVEL_W-1:0]  reg_setup_level,
  output logic [1:0]          reg_setup_mapa,
  output logic [ROUND_W-1:0]  round,
  output logic                playing,
  output logic [POINTS_W-1:0] points,
  output logic [POINTS_W-1:0] best,
  output logic                new_best,
  output logic                win,
  output logic                lose,
  output logic                done
);

  import genius_pkg::*;

  localparam int NLEVELS = 2 ** LEVEL_W;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUND - 1);

  state_t              state;
  logic [POINTS_W-1:0] best_tbl [NLEVELS];
  logic [POINTS_W-1:0] product;

  genius_points_calc #(
    .ROUND_W  (ROUND_W),
    .LEVEL_W  (LEVEL_W),
    .POINTS_W (POINTS_W)
  ) u_points_calc (
    .level   (reg_setup_level),
    .round   (round),
    .product (product)
  );

  assign playing = (state == ST_PLAY);
  assign best    = best_tbl[reg_setup_level];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      reg_setup_level <= '0;
      reg_setup_mapa  <= '0;
      round           <= '0;
      points          <= '0;
      new_best        <= 1'b0;
      win             <= 1'b0;
      lose            <= 1'b0;
      done            <= 1'b0;
      for (int i = 0; i < NLEVELS; i++) begin
        best_tbl[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_RESULT: begin
          // points is deliberately left alone so the last result stays visible
          if (start) begin
            state           <= ST_PLAY;
            reg_setup_level <= setup_level;
            reg_setup_mapa  <= setup_mapa;
            round           <= '0;
            win             <= 1'b0;
            lose            <= 1'b0;
            new_best        <= 1'b0;
          end
        end
        ST_PLAY: begin
          // miss has priority over a simultaneous hit
          if (miss) begin
            lose  <= 1'b1;
            state <= ST_SCORE;
          end else if (hit) begin
            round <= round + ROUND_W'(1);
            if (round == LAST_ROUND) begin
              win   <= 1'b1;
              state <= ST_SCORE;
            end
          end
        end
        ST_SCORE: begin
          points <= product;
          if (product > best_tbl[reg_setup_level]) begin
            best_tbl[reg_setup_level] <= product;
            new_best                  <= 1'b1;
          end
          done  <= 1'b1;
          state <= ST_RESULT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_genius_score_ctrl.sv
// tb/tb_genius_score_ctrl.sv - self-checking bench for genius_score_ctrl against a game-level model
module tb_genius_score_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [1:0] setup_level = '0;
  logic [1:0] setup_mapa = '0;
  logic [1:0] reg_setup_level;
  logic [1:0] reg_setup_mapa;
  logic [3:0] round;
  logic       playing;
  logic [7:0] points;
  logic [7:0] best;
  logic       new_best;
  logic       win;
  logic       lose;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;
  int exp_best [4];
  int last_points = 0;

  genius_score_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .hit             (hit),
    .miss            (miss),
    .setup_level     (setup_level),
    .setup_mapa      (setup_mapa),
    .reg_setup_level (reg_setup_level),
    .reg_setup_mapa  (reg_setup_mapa),
    .round           (round),
    .playing         (playing),
    .points          (points),
    .best            (best),
    .new_best        (new_best),
    .win             (win),
    .lose            (lose),
    .done            (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the next negedge.
  task automatic cycle(input bit s, input bit h, input bit m);
    start = s;
    hit   = h;
    miss  = m;
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    miss  = 1'b0;
  endtask

  task automatic play_game(input int lv, input int mp, input int hits, input bit both);
    int  p;
    bit  nb;
    logic [31:0] lvv;
    logic [31:0] mpv;
    lvv = lv;
    mpv = mp;
    setup_level = lvv[1:0];
    setup_mapa  = mpv[1:0];
    cycle(1, 0, 0);
    check_eq("start_playing", playing, 1);
    check_eq("start_round", round, 0);
    check_eq("start_level", reg_setup_level, lv);
    check_eq("start_mapa", reg_setup_mapa, mp);
    check_eq("start_flags", {win, lose, new_best}, 0);
    check_eq("start_points_kept", points, last_points);
    check_eq("start_best", best, exp_best[lv]);
    for (int i = 0; i < hits; i++) begin
      cycle(0, 1, 0);
      check_eq("hit_round", round, i + 1);
      if (i + 1 < 15) check_eq("hit_playing", playing, 1);
    end
    if (hits == 15) begin
      check_eq("win_playing_drop", playing, 0);
      check_eq("win_flag", {win, lose}, 2'b10);
    end else begin
      cycle(0, both, 1);
      check_eq("miss_flags", {win, lose}, 2'b01);
      check_eq("miss_round", round, hits);
      check_eq("miss_playing", playing, 0);
    end
    p  = lv * hits;
    nb = p > exp_best[lv];
    if (nb) exp_best[lv] = p;
    cycle(0, 0, 0);
    check_eq("result_done", done, 1);
    check_eq("result_points", points, p);
    check_eq("result_new_best", new_best, nb);
    check_eq("result_best", best, exp_best[lv]);
    cycle(0, $urandom_range(0, 1), $urandom_range(0, 1));
    check_eq("hold_done", done, 0);
    check_eq("hold_points", points, p);
    check_eq("hold_round", round, hits);
    check_eq("hold_flags", {win, lose, new_best}, {hits == 15, hits != 15, nb});
    last_points = p;
  endtask

  initial begin
    int lv;
    int hits;
    for (int i = 0; i < 4; i++) exp_best[i] = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {playing, round, points, best, win, lose, new_best, done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    play_game(2, 1, 7, 0);
    play_game(3, 2, 15, 0);
    play_game(1, 0, 3, 1);
    play_game(2, 3, 7, 0);
    play_game(1, 1, 0, 0);

    // start during play is ignored
    setup_level = 2'd1;
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    setup_level = 2'd3;
    cycle(1, 0, 0);
    check_eq("ign_start_round", round, 2);
    check_eq("ign_start_level", reg_setup_level, 1);
    check_eq("ign_start_playing", playing, 1);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    check_eq("pre_reset_round", round, 5);

    // asynchronous reset mid-game
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_round", round, 0);
    check_eq("rst_playing", playing, 0);
    check_eq("rst_points", points, 0);
    check_eq("rst_flags", {win, lose, new_best, done}, 0);
    check_eq("rst_level", reg_setup_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_best[i] = 0;
    last_points = 0;
    cycle(0, 1, 0);
    check_eq("idle_hit_round", round, 0);
    check_eq("idle_hit_playing", playing, 0);
    for (int i = 0; i < 4; i++) play_game(i, i, 0, 0);

    for (int g = 0; g < 40; g++) begin
      lv   = $urandom_range(0, 3);
      hits = ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 14);
      play_game(lv, $urandom_range(0, 3), hits, $urandom_range(0, 1));
      for (int k = 0; k < $urandom_range(0, 3); k++) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1));
      check_eq("idle_noise_points", points, last_points);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
